blink_io_initiator: RTL

- Z80-side bus initiator that runs single I/O read/write cycles against the blink register file (ports 0x70–0xD4).
- Used by the debug/boot loader path and by the bench to program and read blink without a CPU core.
- Takes one command at a time over a valid/ready handshake and drives `ca`, `ior_n`, `crd_n` and the data bus with Z80 IORQ timing.
- Returns read data and status as a one-cycle response pulse.

---
 rtl/blink_io_initiator.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/blink_io_initiator.sv
// Z80-style IORQ initiator: runs one I/O read or write cycle against blink per command.
// Define IOINIT_TIMEOUT_EN to abort cycles whose wait extension exceeds TIMEOUT.
module blink_io_initiator #(
  parameter int unsigned T_SETUP  = 1,
  parameter int unsigned T_STROBE = 3,
  parameter int unsigned T_HOLD   = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] ca,
  output logic        ior_n,
  output logic        crd_n,
  output logic [7:0]  bus_do,
  input  logic [7:0]  bus_di,
  input  logic        wait_n,
  output logic        busy
);

  // One width serves both the phase counter and the wait-extension counter.
  localparam int unsigned MAX_SP  = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int unsigned MAX_SPH = (MAX_SP > T_HOLD) ? MAX_SP : T_HOLD;
  localparam int unsigned MAX_ALL = (MAX_SPH > TIMEOUT) ? MAX_SPH : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(T_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             accept_s, capture_s, wr_s, rd_phase_s, done_s, abort_s;
  logic             wr_r;
  logic [7:0]       rd_data_r;
  logic [15:0]      ca_r;
  logic [7:0]       bus_do_r, rsp_rdata_r;
  logic             ior_n_r, crd_n_r, cmd_ready_r, rsp_valid_r, rsp_err_r, busy_r;

`ifdef IOINIT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] EXT_MAX = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] ext_r;
  logic             to_r, timeout_s, extend_s;
`endif

  // State and phase counter registers
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state decode; the counter reloads whenever a phase is entered
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    accept_s   = 1'b0;
    capture_s  = 1'b0;
`ifdef IOINIT_TIMEOUT_EN
    timeout_s  = 1'b0;
    extend_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          state_s  = ST_SETUP;
          cnt_s    = SETUP_LD;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_STROBE;
          cnt_s   = STROBE_LD;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s     = cnt_r - CNT_ONE;
        end else if (wait_n) begin
          state_s   = ST_HOLD;
          cnt_s     = HOLD_LD;
          capture_s = 1'b1;
`ifdef IOINIT_TIMEOUT_EN
        end else if (ext_r == EXT_MAX) begin
          state_s   = ST_HOLD;
          cnt_s     = HOLD_LD;
          timeout_s = 1'b1;
`endif
        end else begin
          state_s   = ST_STROBE;
`ifdef IOINIT_TIMEOUT_EN
          extend_s  = 1'b1;
`endif
        end
      end
      ST_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_DONE;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase

    // crd_n is decided at accept and held until DONE so it never moves under ior_n
    wr_s       = accept_s ? cmd_wr : wr_r;
    rd_phase_s = (!wr_s) && ((state_s == ST_SETUP) || (state_s == ST_STROBE) ||
                             (state_s == ST_HOLD));
    done_s     = (state_s == ST_DONE);
  end

`ifdef IOINIT_TIMEOUT_EN
  // Wait-extension counter and abort flag, cleared when a new command is accepted
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      ext_r <= CNT_ZERO;
      to_r  <= 1'b0;
    end else if (accept_s) begin
      ext_r <= CNT_ZERO;
      to_r  <= 1'b0;
    end else if (extend_s) begin
      ext_r <= ext_r + CNT_ONE;
    end else if (timeout_s) begin
      to_r  <= 1'b1;
    end
  end

  assign abort_s = to_r;
`else
  assign abort_s = 1'b0;
`endif

  // Bus drive, captured read data and response registers
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      wr_r        <= 1'b0;
      rd_data_r   <= 8'h00;
      ca_r        <= 16'h0000;
      bus_do_r    <= 8'h00;
      ior_n_r     <= 1'b1;
      crd_n_r     <= 1'b1;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 8'h00;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        ca_r <= cmd_addr;
        wr_r <= cmd_wr;
      end
      if (accept_s && cmd_wr) begin
        bus_do_r <= cmd_wdata;
      end
      if (capture_s && !wr_r) begin
        rd_data_r <= bus_di;
      end
      ior_n_r     <= (state_s != ST_STROBE);
      crd_n_r     <= !rd_phase_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      rsp_valid_r <= done_s;
      rsp_err_r   <= done_s && abort_s;
      rsp_rdata_r <= (done_s && !wr_r) ? (abort_s ? 8'hFF : rd_data_r) : 8'h00;
    end
  end

  assign ca        = ca_r;
  assign bus_do    = bus_do_r;
  assign ior_n     = ior_n_r;
  assign crd_n     = crd_n_r;
  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule
